// File: rtl/gi_hi_precompute_stage_if.sv
// rtl/gi_hi_precompute_stage_if.sv - share/randomness input and monomial-word output handshakes
interface gi_hi_precompute_stage_if;
   logic [3:0]  x_share0;
   logic [3:0]  x_share1;
   logic [10:0] rand_in;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] gi_reg;
   logic [14:0] hi_out;
   logic        out_valid;
   logic        out_ready;

   modport master (
      output x_share0, x_share1, rand_in, in_valid, out_ready,
      input  in_ready, gi_reg, hi_out, out_valid
   );

   modport slave (
      input  x_share0, x_share1, rand_in, in_valid, out_ready,
      output in_ready, gi_reg, hi_out, out_valid
   );
endinterface

// File: rtl/gi_hi_precompute_stage.sv
// rtl/gi_hi_precompute_stage.sv - per-share ANF monomials, share-0 masking, elastic output buffer
module gi_hi_precompute_stage #(
   parameter int BUF_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   gi_hi_precompute_stage_if.slave   bus
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

   // Each share gets its own monomial cone; nothing here combines the two shares.
   function automatic logic [14:0] monomials(input logic [3:0] x);
      logic a, b, c, d;
      {a, b, c, d} = x;
      return {a & b & c & d,
              b & c & d, a & c & d, a & b & d, a & b & c,
              c & d, b & d, b & c, a & d, a & c, a & b,
              d, c, b, a};
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   logic [14:0]   gi_mem [BUF_DEPTH];
   logic [14:0]   hi_mem [BUF_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          in_ready_q;
   logic          out_valid;
   logic          push;
   logic          pop;
   logic [14:0]   gi_word;
   logic [14:0]   hi_word;

   assign gi_word   = monomials(bus.x_share0) ^ {bus.rand_in, 4'b0000};
   assign hi_word   = monomials(bus.x_share1);
   assign out_valid = (count != '0);
   assign push      = bus.in_valid && in_ready_q;
   assign pop       = out_valid && bus.out_ready;

   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (!push && pop) begin
         count_next = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         in_ready_q <= 1'b1;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            gi_mem[i] <= '0;
            hi_mem[i] <= '0;
         end
      end else begin
         // Freed entries are scrubbed so no old share data lingers in storage.
         if (pop) begin
            gi_mem[rd_ptr] <= '0;
            hi_mem[rd_ptr] <= '0;
            rd_ptr         <= ptr_inc(rd_ptr);
         end
         if (push) begin
            gi_mem[wr_ptr] <= gi_word;
            hi_mem[wr_ptr] <= hi_word;
            wr_ptr         <= ptr_inc(wr_ptr);
         end
         count      <= count_next;
         in_ready_q <= (count_next < FULL_CNT);
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid;
   assign bus.gi_reg    = out_valid ? gi_mem[rd_ptr] : 15'h0000;
   assign bus.hi_out    = out_valid ? hi_mem[rd_ptr] : 15'h0000;

endmodule

// File: tb/tb_gi_hi_precompute_stage.sv
// tb/tb_gi_hi_precompute_stage.sv - directed bench for gi_hi_precompute_stage
module tb_gi_hi_precompute_stage;

   logic clk = 1'b0;
   logic rst_n;
   logic clear;
   int   checks = 0;
   int   failures = 0;

   gi_hi_precompute_stage_if bus ();

   gi_hi_precompute_stage #(.BUF_DEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Monomial k is the AND of the nibble bits selected by mask k (a=8, b=4, c=2, d=1).
   function automatic logic [14:0] ref_mono(input logic [3:0] x);
      logic [3:0] masks [15];
      logic [14:0] r;
      masks = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'hA, 4'h9, 4'h6, 4'h5, 4'h3,
                4'hE, 4'hD, 4'hB, 4'h7, 4'hF};
      r = '0;
      for (int k = 0; k < 15; k++) r[k] = ((x & masks[k]) == masks[k]);
      return r;
   endfunction

   function automatic logic [14:0] ref_gi(input logic [3:0] x, input logic [10:0] rnd);
      logic [14:0] m;
      m = ref_mono(x);
      for (int k = 4; k < 15; k++) m[k] = m[k] ^ rnd[k-4];
      return m;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] s0, input logic [3:0] s1, input logic [10:0] rnd);
      bus.x_share0 = s0;
      bus.x_share1 = s1;
      bus.rand_in  = rnd;
   endtask

   task automatic check_head(input string tag, input logic [3:0] s0, input logic [3:0] s1,
                             input logic [10:0] rnd);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_gi"}, 32'(bus.gi_reg), 32'(ref_gi(s0, rnd)));
      check({tag, "_hi"}, 32'(bus.hi_out), 32'(ref_mono(s1)));
   endtask

   task automatic check_empty(input string tag);
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_gi"}, 32'(bus.gi_reg), 32'd0);
      check({tag, "_hi"}, 32'(bus.hi_out), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      drive(4'hF, 4'hF, 11'h5A5);

      step();
      step();
      check_empty("reset");
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      step();
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check_empty("post_reset");

      drive(4'b1011, 4'b0110, 11'h000);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("single_valid", 32'(bus.out_valid), 32'd1);
      check("single_gi", 32'(bus.gi_reg), 32'h126D);
      check("single_hi", 32'(bus.hi_out), 32'h0086);
      check("single_in_ready", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check_empty("single_pop");

      drive(4'b1011, 4'b0110, 11'h7FF);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      check("mask_gi", 32'(bus.gi_reg), 32'h6D9D);
      check("mask_hi", 32'(bus.hi_out), 32'h0086);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check_empty("mask_pop");

      bus.in_valid = 1'b1;
      drive(4'h7, 4'h9, 11'h123);
      step();
      check("full_ready1", 32'(bus.in_ready), 32'd1);
      drive(4'hE, 4'h3, 11'h456);
      step();
      check("full_ready2", 32'(bus.in_ready), 32'd0);
      drive(4'h5, 4'hC, 11'h789);
      step();
      bus.in_valid = 1'b0;
      check("full_ready3", 32'(bus.in_ready), 32'd0);
      check_head("full_head1", 4'h7, 4'h9, 11'h123);
      bus.out_ready = 1'b1;
      step();
      check_head("full_head2", 4'hE, 4'h3, 11'h456);
      check("full_drain_ready", 32'(bus.in_ready), 32'd1);
      step();
      check_empty("full_drained");
      step();
      check_empty("full_no_third");
      bus.out_ready = 1'b0;

      drive(4'h0, 4'hF, 11'h000);
      bus.in_valid = 1'b1;
      step();
      for (int i = 1; i <= 8; i++) begin
         drive(4'(i), ~4'(i), 11'(i * 37));
         bus.out_ready = 1'b1;
         step();
         check_head($sformatf("pp%0d", i), 4'(i), ~4'(i), 11'(i * 37));
         check($sformatf("pp%0d_ready", i), 32'(bus.in_ready), 32'd1);
      end
      bus.in_valid = 1'b0;
      step();
      bus.out_ready = 1'b0;
      check_empty("pp_drained");

      bus.in_valid = 1'b1;
      drive(4'h3, 4'h4, 11'h0F0);
      step();
      drive(4'hA, 4'h5, 11'h30F);
      step();
      check_head("clr_pre", 4'h3, 4'h4, 11'h0F0);
      drive(4'hF, 4'hF, 11'h7FF);
      clear = 1'b1;
      step();
      clear = 1'b0;
      bus.in_valid = 1'b0;
      check_empty("clear2");
      check("clear2_ready", 32'(bus.in_ready), 32'd1);

      bus.in_valid = 1'b1;
      drive(4'h6, 4'h1, 11'h2AA);
      step();
      drive(4'hF, 4'hF, 11'h555);
      clear = 1'b1;
      step();
      clear = 1'b0;
      bus.in_valid = 1'b0;
      check_empty("clear1");
      step();
      check_empty("clear1_lost");
      check("clear1_ready", 32'(bus.in_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gi_hi_precompute_stage.md
# gi_hi_precompute_stage

First stage of the two-stage masked AES S-box datapath. It takes one 4-bit nibble in two Boolean shares plus 11 bits of fresh randomness. It computes all 15 ANF monomials per share, masking the share-0 non-linear monomials with the randomness, and registers the results. The registered words are the `gi_reg` / `hi_out` operands consumed directly by the domain-0 sum-of-products stage. A small elastic buffer with valid/ready on both sides decouples randomness/input arrival from the consumer.

## Interface
- `BUF_DEPTH`, default 2: output buffer entries; legal 1..4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `clear`  in  1  synchronous zeroize; drops all buffered entries.
- `x_share0`  in  4  share 0 of nibble; a=[3], b=[2], c=[1], d=[0].
- `x_share1`  in  4  share 1 of nibble, same bit mapping.
- `rand_in`  in  11  fresh mask bits; `rand_in[k]` masks monomial index k+4.
- `in_valid`  in  1  inputs and `rand_in` valid this cycle.
- `in_ready`  out  1  buffer can accept; registered.
- `gi_reg`  out  15  masked share-0 monomial word at buffer head.
- `hi_out`  out  15  share-1 monomial word at buffer head.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer accepts head this cycle.

## Operation
- Monomial index order, for both words: 0 a, 1 b, 2 c, 3 d, 4 ab, 5 ac, 6 ad, 7 bc, 8 bd, 9 cd, 10 abc, 11 abd, 12 acd, 13 bcd, 14 abcd.
- Let m_k(x) be the AND of the bits named by index k.
- `gi[k]` = m_k(`x_share0`) for k in 0..3.
- `gi[k]` = m_k(`x_share0`) XOR `rand_in[k-4]` for k in 4..14.
- `hi[k]` = m_k(`x_share1`) for k in 0..14; unmasked.
- No logic mixes share 0 and share 1. The two monomial cones are separate and are registered before any cross-domain use.
- Push happens when `in_valid` && `in_ready`. The computed {gi, hi} pair is written at the tail.
- Pop happens when `out_valid` && `out_ready`. The head advances.
- The buffer is a circular FIFO of BUF_DEPTH entries with a read pointer, a write pointer and an occupancy count. Pointers wrap modulo BUF_DEPTH.
- Push and pop in the same cycle:
  - Count is unchanged.
  - Both pointers advance.
  - Legal at any occupancy where `in_ready` = 1.
- Full (count == BUF_DEPTH): `in_ready` = 0. `in_valid` is ignored and `rand_in` is not consumed.
- Empty (count == 0): `out_valid` = 0. `out_ready` is ignored.
- `gi_reg`/`hi_out` show the head entry when `out_valid` = 1, and all-zero otherwise. No stale share data is ever driven.
- On a pop, the freed entry is overwritten with zero in that same cycle.
- `clear`, and `rst_n` low, each take effect on the next edge:
  - pointers and count go to 0;
  - all entries are zeroed;
  - any push presented in that cycle is discarded.
- `rst_n` takes priority over `clear`.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `gi_reg` = 0, `hi_out` = 0, all storage = 0.
- Latency is one cycle. A push at edge N is visible on `gi_reg`/`hi_out` with `out_valid` = 1 after edge N, when the buffer was empty.
- `in_ready` is registered, computed as count_next < BUF_DEPTH. It goes low in the cycle after the push that fills the buffer.
- A pop while full raises `in_ready` in the next cycle. There is no same-cycle pass-through from ready to ready.
- `out_valid`, `gi_reg` and `hi_out` are driven from registers or from a register-selected entry. There is no combinational path from any input to any output.
- Throughput is one nibble per cycle when `out_ready` is held at 1.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1. Required: `out_valid`=0, `gi_reg`=`hi_out`=15'h0000, `in_ready`=1 after release.
- Single push: `x_share0`=4'b1011, `x_share1`=4'b0110, `rand_in`=11'h000, `out_ready`=0. Required, one cycle later: `gi_reg`=15'h126D, `hi_out`=15'h0086, `out_valid`=1.
- Masking: same shares with `rand_in`=11'h7FF. Required: `gi_reg`=15'h6D9D, `hi_out`=15'h0086.
- Full/backpressure (BUF_DEPTH=2): push 3 distinct nibbles back-to-back with `out_ready`=0. Required:
  - `in_ready`=0 after the 2nd push;
  - the 3rd push is not accepted;
  - on draining, the order is 1st then 2nd;
  - `out_valid`=0 and zero outputs afterwards.
- Simultaneous push/pop at count 1 for 8 cycles with an incrementing nibble. Required: count stays 1, outputs in order with 1-cycle lag, pointers wrap cleanly.
- Clear mid-stream: with 2 entries buffered, assert `clear` together with `in_valid`. Required: next cycle `out_valid`=0, outputs zero, `in_ready`=1; the pushed nibble is lost.
